// File: rtl/fetch_sequencer.sv
// Instruction fetch / issue / data-access sequencer for a multicycle core.
// Walks FETCH -> ISSUE -> (MEM) -> FETCH, and parks in HALT until reset.
module fetch_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [1:0]  pcSrc,
  input  logic        halt,
  input  logic        memRead,
  input  logic        memWr,
  input  logic [31:0] extimm,
  input  logic [25:0] addr,
  input  logic [31:0] rs_data,
  input  logic        dhit,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_MEM, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, instr_q, retired_q, npc_lat_q;
  logic [31:0] next_pc_d;
  logic        rd_q, wr_q, iren_q, ivalid_q, halted_q;

  assign npc = pc_q + 32'd4;

  always_comb begin
    next_pc_d = npc;
    case (pcSrc)
      2'b01:   next_pc_d = rs_data;
      2'b10:   next_pc_d = {npc[31:28], addr, 2'b00};
      2'b11:   next_pc_d = npc + (extimm << 2);
      default: next_pc_d = npc;
    endcase
  end

  // rd_q/wr_q are only nonzero while in MEM, so they double as the data requests.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_INIT;
      instr_q   <= '0;
      retired_q <= '0;
      npc_lat_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      iren_q    <= 1'b1;
      ivalid_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ihit) begin
            instr_q  <= imemload;
            state_q  <= S_ISSUE;
            iren_q   <= 1'b0;
            ivalid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          ivalid_q <= 1'b0;
          if (halt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            retired_q <= retired_q + 32'd1;
            if (memRead || memWr) begin
              npc_lat_q <= next_pc_d;
              rd_q      <= memRead;
              wr_q      <= memWr;
              state_q   <= S_MEM;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= S_FETCH;
              iren_q  <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (dhit) begin
            pc_q    <= npc_lat_q;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_FETCH;
            iren_q  <= 1'b1;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign iREN        = iren_q;
  assign imemaddr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = ivalid_q;
  assign halted      = halted_q;
  assign retired     = retired_q;
  assign dWEN        = wr_q;
  assign dREN        = rd_q & ~wr_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have ports, one clock and synchronous active-high reset, as follows:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returns data this cycle.
- imemload  in  32  instruction word from instruction memory.
- iREN  out  1  instruction read request.
- imemaddr  out  32  instruction address, always equal to pc.
- instr  out  32  latched instruction word, driven to control unit instr.
- instr_valid  out  1  instr is current and control outputs are being consumed.
- pcSrc  in  2  from control unit: 00 pc+4, 01 jr, 10 j/jal, 11 taken branch.
- halt  in  1  from control unit.
- memRead  in  1  from control unit.
- memWr  in  1  from control unit.
- extimm  in  32  extended immediate from extender.
- addr  in  26  jump target field from control unit.
- rs_data  in  32  register rs value, jr target.
- dhit  in  1  data memory completes access this cycle.
- dREN  out  1  data read request.
- dWEN  out  1  data write request.
- pc  out  32  current PC.
- npc  out  32  pc+4, for jal link.
- halted  out  1  sequencer stopped.
- retired  out  32  count of issued non-halt instructions.

Function
REQ-003 SHALL implement states FETCH, ISSUE, MEM, HALT, as a registered state machine.
REQ-004 FETCH: iREN=1, imemaddr=pc; on ihit latch imemload into instr, go to ISSUE; otherwise remain.
REQ-005 ISSUE, exactly one cycle, instr_valid=1, iREN=0, with transitions:
- halt=1: go to HALT; pc unchanged.
- Else memRead|memWr: latch next PC, memRead and memWr, go to MEM.
- Else: pc <= next PC, go to FETCH.
REQ-006 Next PC, mod 2^32, SHALL be computed from pcSrc as follows:
- 00: pc+4.
- 01: rs_data.
- 10: {npc[31:28], addr, 2'b00}.
- 11: npc + (extimm << 2).
REQ-007 MEM SHALL drive dWEN = latched memWr and dREN = latched memRead & ~latched memWr, so a write wins if both are set.
REQ-008 MEM: on dhit, pc <= latched next PC, go to FETCH; otherwise remain with requests held stable.
REQ-009 HALT: halted=1; iREN, dREN, dWEN, instr_valid all 0; pc, instr and retired frozen; exit only by RST.
REQ-010 retired SHALL increment by 1 in each ISSUE cycle with halt=0, wrapping from 32'hFFFF_FFFF to 0.
REQ-011 ihit outside FETCH and dhit outside MEM SHALL be ignored.
REQ-012 The sequencer SHALL NOT sample control inputs outside ISSUE; inputs in MEM come from latched copies.
REQ-013 npc SHALL equal pc+4 combinationally at all times.
REQ-014 Latency with zero-wait memory SHALL be as follows:
- Non-memory instruction: 2 cycles (FETCH, ISSUE).
- Load or store: 3 cycles.

Reset
REQ-015 RST sampled high at a rising edge SHALL set the following values, overriding any state:
- state=FETCH, pc=PC_INIT, instr=0, retired=0.
- Latched next PC and latched memRead/memWr = 0.
- Outputs follow: iREN=1, dREN=0, dWEN=0, instr_valid=0, halted=0.
REQ-016 RST asserted in MEM or HALT SHALL drop dREN/dWEN/halted in the cycle after the reset edge; the pending access is abandoned.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset, ihit=1 every cycle, imemload=any non-mem, pcSrc=00, halt=0: pc 0,4,8 on alternate cycles; retired increments each ISSUE.
- ISSUE at pc=0x100 with pcSrc=11, extimm=0xFFFF_FFFE: next pc 0xFC. With pcSrc=10, addr=0x0000040: pc 0x100.
- ISSUE at pc=0x20 with memRead=1, dhit low 3 cycles then high: dREN=1 for 4 MEM cycles, then pc=0x24 and FETCH.
- ISSUE with memRead=memWr=1: dWEN=1, dREN=0 throughout MEM.
- ISSUE with halt=1: halted=1 next cycle, pc held, ihit/dhit pulses cause no change; RST then restores pc=PC_INIT, halted=0.
- RST asserted mid-MEM with dWEN=1: dWEN=0 and state FETCH after the edge; retired=0.
